multicycle_controller: RTL and testbench

- Moore finite-state-machine (FSM) controller that sequences a multicycle RV32I-subset datapath: shared instruction/data memory, IR, OldPC, Data, ALUOut registers.
- Decodes op per instruction phase, drives all datapath enables and mux selects, and stalls on a memory-ready handshake.
- Keeps a retired-instruction counter and halts on unsupported opcodes.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle RV32I-subset datapath with a shared
// instruction/data memory. Sequences fetch/decode/execute phases, drives all
// datapath enables and mux selects, stalls on mem_ready, counts retired
// instructions and traps unsupported opcodes into a sticky HALT state.
module multicycle_controller #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             RegWrite,
    output logic             instr_done,
    output logic             halted,
    output logic [RET_W-1:0] instret,
    output logic [3:0]       state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    state_t           state_r;
    logic [RET_W-1:0] instret_r;

    // Enables before the reset gate; only these are forced low during reset.
    logic pc_write_s;
    logic mem_write_s;
    logic ir_write_s;
    logic reg_write_s;
    logic instr_done_s;
    logic halted_s;
    logic adr_src_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] imm_src_s;

    // State sequencing and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            instret_r <= {RET_W{1'b0}};
        end else begin
            if (instr_done_s) begin
                instret_r <= instret_r + RET_W'(1);
            end else begin
                instret_r <= instret_r;
            end
            case (state_r)
                S_FETCH: begin
                    if (mem_ready) state_r <= S_DECODE;
                    else           state_r <= S_FETCH;
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_r <= S_MEMADR;
                        OP_R:         state_r <= S_EXECR;
                        OP_I:         state_r <= S_EXECI;
                        OP_BEQ:       state_r <= S_BEQ;
                        OP_JAL:       state_r <= S_JAL;
                        default:      state_r <= S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    // op is held by IR, so anything but lw/sw here is corrupt.
                    if (op == OP_LW)      state_r <= S_MEMREAD;
                    else if (op == OP_SW) state_r <= S_MEMWRITE;
                    else                  state_r <= S_HALT;
                end
                S_MEMREAD: begin
                    if (mem_ready) state_r <= S_MEMWB;
                    else           state_r <= S_MEMREAD;
                end
                S_MEMWB:    state_r <= S_FETCH;
                S_MEMWRITE: begin
                    if (mem_ready) state_r <= S_FETCH;
                    else           state_r <= S_MEMWRITE;
                end
                S_EXECR:    state_r <= S_ALUWB;
                S_EXECI:    state_r <= S_ALUWB;
                S_ALUWB:    state_r <= S_FETCH;
                S_JAL:      state_r <= S_ALUWB;
                S_BEQ:      state_r <= S_FETCH;
                S_HALT:     state_r <= S_HALT;
                default:    state_r <= S_HALT;
            endcase
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_SW:   imm_src_s = 2'b01;
            OP_BEQ:  imm_src_s = 2'b10;
            OP_JAL:  imm_src_s = 2'b11;
            default: imm_src_s = 2'b00;
        endcase
    end

    // Moore output decode; only memory/branch enables look at mem_ready/zero.
    always_comb begin
        pc_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        halted_s     = 1'b0;
        adr_src_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        case (state_r)
            S_FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready;
            end
            S_EXECR: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
            end
            S_EXECI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b01;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b10;
                pc_write_s   = zero;
                instr_done_s = 1'b1;
            end
            S_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is asserted.
    assign PCWrite    = pc_write_s   & rst_n;
    assign IRWrite    = ir_write_s   & rst_n;
    assign MemWrite   = mem_write_s  & rst_n;
    assign RegWrite   = reg_write_s  & rst_n;
    assign instr_done = instr_done_s & rst_n;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ALUOp      = alu_op_s;
    assign ImmSrc     = imm_src_s;
    assign halted     = halted_s;
    assign instret    = instret_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each table row is one cycle:
// {mem_ready, zero, expected outputs}. Expected output packing:
// PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc
// RegWrite instr_done halted state
module tb_multicycle_controller;

    localparam int RET_W = 4;

    logic             clk;
    logic             rst_n;
    logic [6:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic             instr_done, halted;
    logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [RET_W-1:0] instret;
    logic [3:0]       state;
    logic [20:0]      outs;

    int checks;
    int failures;

    multicycle_controller #(.RET_W(RET_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
        .halted(halted), .instret(instret), .state(state)
    );

    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUOp, ImmSrc, RegWrite, instr_done, halted, state};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; op = 7'b0110011; mem_ready = 1'b1; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== 21'b0_0_0_0_10_00_10_00_00_0_0_0_0000) begin
            failures++; $display("FAIL reset_outs got %b expected %b", outs, 21'b0_0_0_0_10_00_10_00_00_0_0_0_0000);
        end
        checks++;
        if (instret !== 4'd0) begin
            failures++; $display("FAIL reset_instret got %0d expected 0", instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [22:0] vec [4];
        vec = '{ {2'b10, 21'b1_0_0_1_10_00_10_00_00_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_00_0_0_0_0001},
                 {2'b10, 21'b0_0_0_0_00_10_00_01_00_0_0_0_0110},
                 {2'b10, 21'b0_0_0_0_00_00_00_00_00_1_1_0_1000} };
        op = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = vec[i][22]; zero = vec[i][21]; #1;
            checks++;
            if (outs !== vec[i][20:0]) begin
                failures++; $display("FAIL rtype cycle %0d got %b expected %b", i, outs, vec[i][20:0]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 4'd1 || state !== 4'd0) begin
            failures++; $display("FAIL rtype_end instret=%0d state=%0d expected 1 0", instret, state);
        end
    endtask

    task automatic test_lw_stall();
        logic [22:0] vec [10];
        vec = '{ {2'b00, 21'b0_0_0_0_10_00_10_00_00_0_0_0_0000},
                 {2'b00, 21'b0_0_0_0_10_00_10_00_00_0_0_0_0000},
                 {2'b10, 21'b1_0_0_1_10_00_10_00_00_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_00_0_0_0_0001},
                 {2'b10, 21'b0_0_0_0_00_10_01_00_00_0_0_0_0010},
                 {2'b00, 21'b0_1_0_0_00_00_00_00_00_0_0_0_0011},
                 {2'b00, 21'b0_1_0_0_00_00_00_00_00_0_0_0_0011},
                 {2'b00, 21'b0_1_0_0_00_00_00_00_00_0_0_0_0011},
                 {2'b10, 21'b0_1_0_0_00_00_00_00_00_0_0_0_0011},
                 {2'b10, 21'b0_0_0_0_01_00_00_00_00_1_1_0_0100} };
        op = 7'b0000011;
        for (int i = 0; i < 10; i++) begin
            mem_ready = vec[i][22]; zero = vec[i][21]; #1;
            checks++;
            if (outs !== vec[i][20:0]) begin
                failures++; $display("FAIL lw cycle %0d got %b expected %b", i, outs, vec[i][20:0]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 4'd2 || state !== 4'd0) begin
            failures++; $display("FAIL lw_end instret=%0d state=%0d expected 2 0", instret, state);
        end
    endtask

    task automatic test_sw_stall();
        logic [22:0] vec [6];
        vec = '{ {2'b10, 21'b1_0_0_1_10_00_10_00_01_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_01_0_0_0_0001},
                 {2'b10, 21'b0_0_0_0_00_10_01_00_01_0_0_0_0010},
                 {2'b00, 21'b0_1_1_0_00_00_00_00_01_0_0_0_0101},
                 {2'b00, 21'b0_1_1_0_00_00_00_00_01_0_0_0_0101},
                 {2'b10, 21'b0_1_1_0_00_00_00_00_01_0_1_0_0101} };
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = vec[i][22]; zero = vec[i][21]; #1;
            checks++;
            if (outs !== vec[i][20:0]) begin
                failures++; $display("FAIL sw cycle %0d got %b expected %b", i, outs, vec[i][20:0]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 4'd3 || state !== 4'd0) begin
            failures++; $display("FAIL sw_end instret=%0d state=%0d expected 3 0", instret, state);
        end
    endtask

    task automatic test_beq();
        logic [22:0] vec [6];
        vec = '{ {2'b11, 21'b1_0_0_1_10_00_10_00_10_0_0_0_0000},
                 {2'b11, 21'b0_0_0_0_00_01_01_00_10_0_0_0_0001},
                 {2'b11, 21'b1_0_0_0_00_10_00_10_10_0_1_0_1010},
                 {2'b10, 21'b1_0_0_1_10_00_10_00_10_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_10_0_0_0_0001},
                 {2'b10, 21'b0_0_0_0_00_10_00_10_10_0_1_0_1010} };
        op = 7'b1100011;
        for (int i = 0; i < 6; i++) begin
            mem_ready = vec[i][22]; zero = vec[i][21]; #1;
            checks++;
            if (outs !== vec[i][20:0]) begin
                failures++; $display("FAIL beq cycle %0d got %b expected %b", i, outs, vec[i][20:0]);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 4'd5 || state !== 4'd0) begin
            failures++; $display("FAIL beq_end instret=%0d state=%0d expected 5 0", instret, state);
        end
    endtask

    task automatic test_jal_halt();
        logic [22:0] vec [6];
        vec = '{ {2'b10, 21'b1_0_0_1_10_00_10_00_11_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_11_0_0_0_0001},
                 {2'b10, 21'b1_0_0_0_00_01_10_00_11_0_0_0_1001},
                 {2'b10, 21'b0_0_0_0_00_00_00_00_11_1_1_0_1000},
                 {2'b10, 21'b1_0_0_1_10_00_10_00_00_0_0_0_0000},
                 {2'b10, 21'b0_0_0_0_00_01_01_00_00_0_0_0_0001} };
        for (int i = 0; i < 6; i++) begin
            op = (i < 4) ? 7'b1101111 : 7'b1111111;
            mem_ready = vec[i][22]; zero = vec[i][21]; #1;
            checks++;
            if (outs !== vec[i][20:0]) begin
                failures++; $display("FAIL jal_halt cycle %0d got %b expected %b", i, outs, vec[i][20:0]);
            end
            @(negedge clk);
        end
        // Sticky HALT: toggle mem_ready/zero, enables must stay low.
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; zero = i[1]; #1;
            checks++;
            if (outs !== 21'b0_0_0_0_00_00_00_00_00_0_0_1_1111) begin
                failures++; $display("FAIL halt cycle %0d got %b expected %b", i, outs, 21'b0_0_0_0_00_00_00_00_00_0_0_1_1111);
            end
            @(negedge clk);
        end
        checks++;
        if (instret !== 4'd6) begin
            failures++; $display("FAIL halt_instret got %0d expected 6", instret);
        end
        // Reset clears HALT and the counter.
        #1 rst_n = 1'b0; #1;
        checks++;
        if (halted !== 1'b0 || state !== 4'd0 || instret !== 4'd0) begin
            failures++; $display("FAIL halt_reset halted=%b state=%0d instret=%0d expected 0 0 0", halted, state, instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_write();
        op = 7'b1100011; mem_ready = 1'b1; zero = 1'b0;
        repeat (15 * 3) @(negedge clk);
        checks++;
        if (instret !== 4'hF) begin
            failures++; $display("FAIL preload_instret got %0d expected 15", instret);
        end
        op = 7'b0100011;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0; #1;
        checks++;
        if (MemWrite !== 1'b1 || state !== 4'd5) begin
            failures++; $display("FAIL midwrite_pre MemWrite=%b state=%0d expected 1 5", MemWrite, state);
        end
        #1 rst_n = 1'b0; #1;
        checks++;
        if (outs !== 21'b0_0_0_0_10_00_10_00_01_0_0_0_0000 || instret !== 4'd0) begin
            failures++; $display("FAIL midwrite_reset got %b instret=%0d expected %b 0", outs, instret, 21'b0_0_0_0_10_00_10_00_01_0_0_0_0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back_wrap();
        op = 7'b1100011; mem_ready = 1'b1; zero = 1'b0;
        repeat (15 * 3) @(negedge clk);
        checks++;
        if (instret !== 4'hF) begin
            failures++; $display("FAIL wrap_15 got %0d expected 15", instret);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (instret !== 4'd0 || state !== 4'd0) begin
            failures++; $display("FAIL wrap_16 instret=%0d state=%0d expected 0 0", instret, state);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_jal_halt();
        test_reset_mid_write();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
